tcdm_amo_bank_adapter: RTL and testbench
========================================

# tcdm_amo_bank_adapter

Per-bank atomic adapter placed between the TCDM logarithmic interconnect output port and one SRAM bank. It is the parametrised successor of the cluster's AMO shim: configurable data width and master count, the full RISC-V A-extension set including LR/SC reservation tracking per master, and an explicit response-valid output. One instance sits on each TCDM bank.

## Interface
- `DataWidth`, 32: bank word width; 32 or 64.
- `AddrMemWidth`, 11: word address width into the bank.
- `NumMasters`, 16: number of interconnect initiators; sets reservation-table depth.
- `IdWidth`, `$clog2(NumMasters)`: initiator ID width.
- `BeWidth`, `DataWidth/8`: byte-enable width.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset. Single clock domain; reset is synchronous and active-low.
- `in_req_i` in 1: request from the interconnect.
- `in_gnt_o` out 1: grant.
- `in_add_i` in AddrMemWidth: word address.
- `in_wen_i` in 1: 0 = write, 1 = read.
- `in_wdata_i` in DataWidth: write data or AMO operand.
- `in_be_i` in BeWidth: byte enables.
- `in_atop_i` in 6: bit 5 = atomic valid; [4:0] = RISC-V funct5.
- `in_id_i` in IdWidth: initiator ID.
- `in_rdata_o` out DataWidth: response data.
- `in_rvalid_o` out 1: response valid, for reads and writes.
- `out_req_o` out 1: SRAM request.
- `out_add_o` out AddrMemWidth: SRAM address.
- `out_wen_o` out 1: 0 = write.
- `out_wdata_o` out DataWidth: SRAM write data.
- `out_be_o` out BeWidth: SRAM byte enables.
- `out_rdata_i` in DataWidth: SRAM read data, valid 1 cycle after the request.

## Operation
- **FSM states.** IDLE and AMO_WB.
  - IDLE: `in_gnt_o = 1`. Plain read and write requests pass through combinationally to the SRAM.
  - IDLE → AMO_WB: on a granted AMO (ADD, SWAP, XOR, OR, AND, MIN, MAX, MINU, MAXU). The SRAM read is issued in that cycle and the operands are latched.
  - AMO_WB: `in_gnt_o = 0`. The unit computes `f(old, operand)` and writes it with `out_be_o` all ones. Transition back to IDLE.
- **AMO arithmetic.**
  - AMOs act on the full DataWidth word; `in_be_i` is ignored.
  - MIN/MAX compare signed; MINU/MAXU compare unsigned.
  - ADD wraps modulo 2^DataWidth.
  - Response data is the old memory value.
- **Illegal encodings.** atop[5]=1 with an undefined funct5 is treated as a plain access. Simulation builds report an `$error`.
- **Reservation table.** One entry per ID: valid bit plus address.
  - LR: reads the word and sets entry[id] to {1, addr}, overwriting any previous entry.
  - SC: succeeds if entry[id] is valid and its address equals `in_add_i`. On success the write is issued in the same cycle and the response is 0. On failure there is no SRAM request and the response is 1. entry[id] is cleared in either case.
  - Any committed write (plain write, AMO writeback, or successful SC) clears every valid entry whose address matches, including the writer's own.
- **Simultaneous events.** An LR and a clearing write in the same cycle cannot occur, because there is a single port.
- **Reset.** `rst_ni=0` at a clock edge:
  - FSM returns to IDLE.
  - A pending AMO writeback is discarded.
  - All reservations are cleared.

## Timing
- Plain read or write: granted in cycle t; `in_rvalid_o` in t+1, with read data from `out_rdata_i`.
- AMO:
  - Granted and read issued in t.
  - In t+1: writeback, `in_rvalid_o=1` with the old value, and `in_gnt_o=0`.
  - The next request can be granted in t+2. Throughput is one AMO per 2 cycles.
- LR and SC: single cycle; response in t+1.
- A request held during AMO_WB is granted in the following IDLE cycle.
- Reset values:
  - `in_gnt_o=0` while `rst_ni=0`.
  - `in_rvalid_o=0`, `in_rdata_o=0`, `out_req_o=0`, `out_wen_o=1`.
  - Reservation valid bits are all 0.

## Configuration
- `TCDM_AMO_LRSC_EN` defined: the reservation table and LR/SC semantics are built as above.
- `TCDM_AMO_LRSC_EN` undefined:
  - No table is instantiated.
  - LR behaves as a plain read.
  - SC always fails: no write, response 1.
  - Simulation builds emit an `$warning` on the first SC.

## Test plan
- Plain traffic: write 0xDEADBEEF to addr 5, then read addr 5 → `in_rvalid_o` in the cycle after each grant; read returns 0xDEADBEEF.
- AMO_ADD: mem[3]=0xFFFFFFFF, AMO_ADD operand 2 → response 0xFFFFFFFF, mem[3]=0x00000001, `in_gnt_o` low for exactly 1 cycle.
- Signed versus unsigned compare: mem[7]=0x80000000; AMO_MAX with 1 → mem[7]=1; reset mem[7]=0x80000000; AMO_MAXU with 1 → mem[7]=0x80000000.
- LR/SC success: ID 2 does LR addr 9, then SC addr 9 with data 0x55 → SC response 0, mem[9]=0x55.
- LR/SC failure: ID 2 does LR addr 9, ID 4 writes addr 9, then ID 2 does SC addr 9 → response 1, mem[9] unchanged, no `out_req_o` during the SC. Repeat with the macro undefined: SC always returns 1.
- Reset mid-AMO: assert `rst_ni=0` in the AMO_WB cycle → no SRAM write occurs, `in_rvalid_o=0`, and a subsequent SC from an ID that had a prior LR returns 1.

Source files
------------

// File: rtl/tcdm_amo_bank_adapter.sv
// tcdm_amo_bank_adapter
//   Per-bank atomic adapter between a TCDM interconnect output port and one
//   SRAM bank. Plain reads and writes pass straight through to the SRAM. AMOs
//   are executed as a read in the grant cycle followed by a full-word
//   writeback in the next cycle, which stalls the grant for one cycle.
//   LR/SC uses a per-initiator reservation table. Every granted request gets
//   a response (in_rvalid_o) one cycle after its grant.
//
//   Optional feature macro: TCDM_AMO_LRSC_EN
//     defined   -> reservation table built, LR/SC fully supported
//     undefined -> no table, LR is a plain read, SC always fails (response 1)
//
// Ports
//   clk_i, rst_ni          clock, synchronous active-low reset
//   in_req_i / in_gnt_o    interconnect request / grant
//   in_add_i, in_wen_i     word address, 0 = write / 1 = read
//   in_wdata_i, in_be_i    write data or AMO operand, byte enables
//   in_atop_i              [5] atomic valid, [4:0] RISC-V funct5
//   in_id_i                initiator ID
//   in_rdata_o, in_rvalid_o response data and valid
//   out_req_o .. out_be_o  SRAM request, address, write enable, data, strobes
//   out_rdata_i            SRAM read data, valid one cycle after the request
module tcdm_amo_bank_adapter #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned AddrMemWidth = 11,
  parameter int unsigned NumMasters   = 16,
  parameter int unsigned IdWidth      = $clog2(NumMasters),
  parameter int unsigned BeWidth      = DataWidth / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    in_req_i,
  output logic                    in_gnt_o,
  input  logic [AddrMemWidth-1:0] in_add_i,
  input  logic                    in_wen_i,
  input  logic [DataWidth-1:0]    in_wdata_i,
  input  logic [BeWidth-1:0]      in_be_i,
  input  logic [5:0]              in_atop_i,
  input  logic [IdWidth-1:0]      in_id_i,
  output logic [DataWidth-1:0]    in_rdata_o,
  output logic                    in_rvalid_o,
  output logic                    out_req_o,
  output logic [AddrMemWidth-1:0] out_add_o,
  output logic                    out_wen_o,
  output logic [DataWidth-1:0]    out_wdata_o,
  output logic [BeWidth-1:0]      out_be_o,
  input  logic [DataWidth-1:0]    out_rdata_i
);

  localparam logic [4:0] AmoAdd  = 5'b00000;
  localparam logic [4:0] AmoSwap = 5'b00001;
  localparam logic [4:0] AmoLr   = 5'b00010;
  localparam logic [4:0] AmoSc   = 5'b00011;
  localparam logic [4:0] AmoXor  = 5'b00100;
  localparam logic [4:0] AmoOr   = 5'b01000;
  localparam logic [4:0] AmoAnd  = 5'b01100;
  localparam logic [4:0] AmoMin  = 5'b10000;
  localparam logic [4:0] AmoMax  = 5'b10100;
  localparam logic [4:0] AmoMinu = 5'b11000;
  localparam logic [4:0] AmoMaxu = 5'b11100;

  typedef enum logic {IDLE, AMO_WB} state_e;

  state_e                  state;
  logic [AddrMemWidth-1:0] amo_addr;
  logic [DataWidth-1:0]    amo_operand;
  logic [4:0]              amo_op;
  logic [DataWidth-1:0]    amo_result;
  logic                    rvalid_q;
  logic                    sc_resp;
  logic                    sc_fail;
  logic                    grant;
  logic                    is_amo;
  logic                    is_lr;
  logic                    is_sc;
  logic                    sc_ok;
  logic [4:0]              funct;

  assign funct    = in_atop_i[4:0];
  assign in_gnt_o = rst_ni && (state == IDLE);
  assign grant    = in_req_i && in_gnt_o;

  // Undefined funct5 codes fall through as plain accesses.
  always_comb begin
    is_amo = 1'b0;
    is_lr  = 1'b0;
    is_sc  = 1'b0;
    if (in_atop_i[5]) begin
      case (funct)
        AmoAdd, AmoSwap, AmoXor, AmoOr, AmoAnd,
        AmoMin, AmoMax, AmoMinu, AmoMaxu: is_amo = 1'b1;
        AmoLr:   is_lr = 1'b1;
        AmoSc:   is_sc = 1'b1;
        default: is_amo = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (amo_op)
      AmoAdd:  amo_result = out_rdata_i + amo_operand;
      AmoXor:  amo_result = out_rdata_i ^ amo_operand;
      AmoOr:   amo_result = out_rdata_i | amo_operand;
      AmoAnd:  amo_result = out_rdata_i & amo_operand;
      AmoMin:  amo_result = ($signed(out_rdata_i) < $signed(amo_operand)) ? out_rdata_i : amo_operand;
      AmoMax:  amo_result = ($signed(out_rdata_i) > $signed(amo_operand)) ? out_rdata_i : amo_operand;
      AmoMinu: amo_result = (out_rdata_i < amo_operand) ? out_rdata_i : amo_operand;
      AmoMaxu: amo_result = (out_rdata_i > amo_operand) ? out_rdata_i : amo_operand;
      default: amo_result = amo_operand;
    endcase
  end

  // The writeback is squashed combinationally when reset is asserted during
  // AMO_WB so the pending write never reaches the SRAM.
  always_comb begin
    out_req_o   = 1'b0;
    out_add_o   = in_add_i;
    out_wen_o   = 1'b1;
    out_wdata_o = in_wdata_i;
    out_be_o    = in_be_i;
    if (state == AMO_WB) begin
      out_req_o   = rst_ni;
      out_add_o   = amo_addr;
      out_wen_o   = ~rst_ni;
      out_wdata_o = amo_result;
      out_be_o    = '1;
    end else if (grant) begin
      if (is_amo || is_lr) begin
        out_req_o = 1'b1;
        out_wen_o = 1'b1;
      end else if (is_sc) begin
        out_req_o = sc_ok;
        out_wen_o = ~sc_ok;
      end else begin
        out_req_o = 1'b1;
        out_wen_o = in_wen_i;
      end
    end
  end

  assign in_rvalid_o = rvalid_q && rst_ni;
  assign in_rdata_o  = !in_rvalid_o ? '0 :
                       sc_resp      ? DataWidth'(sc_fail) : out_rdata_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      rvalid_q    <= 1'b0;
      sc_resp     <= 1'b0;
      sc_fail     <= 1'b0;
      amo_addr    <= '0;
      amo_operand <= '0;
      amo_op      <= '0;
    end else begin
      rvalid_q <= grant;
      sc_resp  <= grant && is_sc;
      sc_fail  <= ~sc_ok;
      case (state)
        IDLE: begin
          if (grant && is_amo) begin
            state       <= AMO_WB;
            amo_addr    <= in_add_i;
            amo_operand <= in_wdata_i;
            amo_op      <= funct;
          end
        end
        AMO_WB:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TCDM_AMO_LRSC_EN
  logic [NumMasters-1:0]   res_valid;
  logic [AddrMemWidth-1:0] res_addr [NumMasters];
  logic                    wr_commit;

  assign sc_ok     = res_valid[in_id_i] && (res_addr[in_id_i] == in_add_i);
  assign wr_commit = out_req_o && !out_wen_o;

  // Any committed write kills matching reservations first; the LR/SC update
  // of the requester's own entry is applied afterwards and takes priority.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      res_valid <= '0;
    end else begin
      for (int i = 0; i < int'(NumMasters); i++) begin
        if (wr_commit && res_valid[i] && (res_addr[i] == out_add_o)) begin
          res_valid[i] <= 1'b0;
        end
      end
      if (grant && is_lr) begin
        res_valid[in_id_i] <= 1'b1;
        res_addr[in_id_i]  <= in_add_i;
      end else if (grant && is_sc) begin
        res_valid[in_id_i] <= 1'b0;
      end
    end
  end
`else
  assign sc_ok = 1'b0;

`ifndef SYNTHESIS
  logic sc_warned;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sc_warned <= 1'b0;
    end else if (grant && is_sc && !sc_warned) begin
      sc_warned <= 1'b1;
      $warning("tcdm_amo_bank_adapter: SC from id %0d without LR/SC support, returning 1", in_id_i);
    end
  end
`endif
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni && grant && in_atop_i[5] && !(is_amo || is_lr || is_sc)) begin
      $error("tcdm_amo_bank_adapter: undefined atomic funct5 0x%02h treated as plain access", funct);
    end
  end
`endif

endmodule

// File: tb/tb_tcdm_amo_bank_adapter.sv
// tb_tcdm_amo_bank_adapter
//   Directed self-checking bench for tcdm_amo_bank_adapter with the default
//   parameters (32-bit data, 11-bit address, 16 masters). A behavioural SRAM
//   with one cycle read latency sits on the out_* port. Expected LR/SC
//   results follow the TCDM_AMO_LRSC_EN build option.
module tb_tcdm_amo_bank_adapter;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int IW = 4;
  localparam int BW = 4;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SWAP = 5'b00001;
  localparam logic [4:0] F_LR   = 5'b00010;
  localparam logic [4:0] F_SC   = 5'b00011;
  localparam logic [4:0] F_XOR  = 5'b00100;
  localparam logic [4:0] F_MIN  = 5'b10000;
  localparam logic [4:0] F_MAX  = 5'b10100;
  localparam logic [4:0] F_MINU = 5'b11000;
  localparam logic [4:0] F_MAXU = 5'b11100;

`ifdef TCDM_AMO_LRSC_EN
  localparam bit LrscEn = 1'b1;
`else
  localparam bit LrscEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_req;
  logic          in_gnt;
  logic [AW-1:0] in_add;
  logic          in_wen;
  logic [DW-1:0] in_wdata;
  logic [BW-1:0] in_be;
  logic [5:0]    in_atop;
  logic [IW-1:0] in_id;
  logic [DW-1:0] in_rdata;
  logic          in_rvalid;
  logic          out_req;
  logic [AW-1:0] out_add;
  logic          out_wen;
  logic [DW-1:0] out_wdata;
  logic [BW-1:0] out_be;
  logic [DW-1:0] sram_rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tcdm_amo_bank_adapter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_req_i    (in_req),
    .in_gnt_o    (in_gnt),
    .in_add_i    (in_add),
    .in_wen_i    (in_wen),
    .in_wdata_i  (in_wdata),
    .in_be_i     (in_be),
    .in_atop_i   (in_atop),
    .in_id_i     (in_id),
    .in_rdata_o  (in_rdata),
    .in_rvalid_o (in_rvalid),
    .out_req_o   (out_req),
    .out_add_o   (out_add),
    .out_wen_o   (out_wen),
    .out_wdata_o (out_wdata),
    .out_be_o    (out_be),
    .out_rdata_i (sram_rdata)
  );

  // Behavioural SRAM bank: byte-strobed writes, registered reads.
  always @(posedge clk) begin
    if (out_req) begin
      if (!out_wen) begin
        for (int b = 0; b < BW; b++) begin
          if (out_be[b]) mem[out_add][8*b +: 8] <= out_wdata[8*b +: 8];
        end
      end else begin
        sram_rdata <= mem[out_add];
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic wen, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [5:0] atop, input logic [IW-1:0] id);
    in_req   = req;
    in_wen   = wen;
    in_add   = addr;
    in_wdata = wdata;
    in_be    = req ? '1 : '0;
    in_atop  = atop;
    in_id    = id;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b1, '0, '0, 6'd0, '0);
  endtask

  task automatic plainWrite(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, addr, data, 6'd0, id);
    #1;
    checkOutput({tag, "_wr_req"}, DW'(out_req), 1);
    checkOutput({tag, "_wr_wen"}, DW'(out_wen), 0);
    @(negedge clk);
    idle();
    #1;
    checkOutput({tag, "_wr_rvalid"}, DW'(in_rvalid), 1);
    checkOutput({tag, "_wr_mem"}, mem[addr], data);
  endtask

  task automatic plainRead(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] expData);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, addr, '0, 6'd0, '0);
    #1;
    checkOutput({tag, "_rd_gnt"}, DW'(in_gnt), 1);
    @(negedge clk);
    idle();
    #1;
    checkOutput({tag, "_rd_rvalid"}, DW'(in_rvalid), 1);
    checkOutput({tag, "_rd_data"}, in_rdata, expData);
    @(negedge clk);
    #1;
    checkOutput({tag, "_rd_rvalid_off"}, DW'(in_rvalid), 0);
  endtask

  // With holdRead set, a plain read of the same word is presented during the
  // writeback cycle and must be granted only in the following IDLE cycle.
  task automatic doAmo(input string tag, input logic [4:0] f5, input logic [AW-1:0] addr,
                       input logic [DW-1:0] operand, input logic [DW-1:0] expOld,
                       input logic [DW-1:0] expNew, input bit holdRead);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, addr, operand, {1'b1, f5}, '0);
    #1;
    checkOutput({tag, "_gnt_t"}, DW'(in_gnt), 1);
    checkOutput({tag, "_rd_wen_t"}, DW'(out_wen), 1);
    @(negedge clk);
    if (holdRead) applyStimulus(1'b1, 1'b1, addr, '0, 6'd0, '0);
    else idle();
    #1;
    checkOutput({tag, "_gnt_wb"}, DW'(in_gnt), 0);
    checkOutput({tag, "_wb_req"}, DW'(out_req), 1);
    checkOutput({tag, "_wb_wen"}, DW'(out_wen), 0);
    checkOutput({tag, "_wb_be"}, DW'(out_be), 32'hF);
    checkOutput({tag, "_wb_data"}, out_wdata, expNew);
    checkOutput({tag, "_rvalid"}, DW'(in_rvalid), 1);
    checkOutput({tag, "_old"}, in_rdata, expOld);
    @(negedge clk);
    #1;
    checkOutput({tag, "_gnt_back"}, DW'(in_gnt), 1);
    checkOutput({tag, "_mem"}, mem[addr], expNew);
    if (holdRead) begin
      checkOutput({tag, "_held_req"}, DW'(out_req), 1);
      checkOutput({tag, "_held_wen"}, DW'(out_wen), 1);
      @(negedge clk);
      idle();
      #1;
      checkOutput({tag, "_held_rvalid"}, DW'(in_rvalid), 1);
      checkOutput({tag, "_held_data"}, in_rdata, expNew);
    end
  endtask

  task automatic doLr(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [DW-1:0] expData);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, addr, '0, {1'b1, F_LR}, id);
    #1;
    checkOutput({tag, "_lr_req"}, DW'(out_req), 1);
    @(negedge clk);
    idle();
    #1;
    checkOutput({tag, "_lr_rvalid"}, DW'(in_rvalid), 1);
    checkOutput({tag, "_lr_data"}, in_rdata, expData);
  endtask

  task automatic doSc(input string tag, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic [DW-1:0] expResp, input logic expReq);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, addr, data, {1'b1, F_SC}, id);
    #1;
    checkOutput({tag, "_sc_req"}, DW'(out_req), DW'(expReq));
    checkOutput({tag, "_sc_wen"}, DW'(out_wen), DW'(!expReq));
    @(negedge clk);
    idle();
    #1;
    checkOutput({tag, "_sc_rvalid"}, DW'(in_rvalid), 1);
    checkOutput({tag, "_sc_resp"}, in_rdata, expResp);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_gnt", DW'(in_gnt), 0);
    checkOutput("rst_rvalid", DW'(in_rvalid), 0);
    checkOutput("rst_rdata", in_rdata, 0);
    checkOutput("rst_out_req", DW'(out_req), 0);
    checkOutput("rst_out_wen", DW'(out_wen), 1);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_gnt", DW'(in_gnt), 1);

    plainWrite("plain", 4'd0, 11'd5, 32'hDEADBEEF);
    plainRead("plain", 11'd5, 32'hDEADBEEF);

    plainWrite("add_init", 4'd0, 11'd3, 32'hFFFFFFFF);
    doAmo("add", F_ADD, 11'd3, 32'd2, 32'hFFFFFFFF, 32'h00000001, 1'b0);

    plainWrite("max_init", 4'd0, 11'd7, 32'h80000000);
    doAmo("max", F_MAX, 11'd7, 32'd1, 32'h80000000, 32'h00000001, 1'b0);
    plainWrite("maxu_init", 4'd0, 11'd7, 32'h80000000);
    doAmo("maxu", F_MAXU, 11'd7, 32'd1, 32'h80000000, 32'h80000000, 1'b1);
    doAmo("min", F_MIN, 11'd7, 32'd1, 32'h80000000, 32'h80000000, 1'b0);
    doAmo("minu", F_MINU, 11'd7, 32'd1, 32'h80000000, 32'h00000001, 1'b0);

    plainWrite("xor_init", 4'd0, 11'd4, 32'h0F0F00FF);
    doAmo("xor", F_XOR, 11'd4, 32'hFF00FF00, 32'h0F0F00FF, 32'hF00FFFFF, 1'b0);
    doAmo("swap", F_SWAP, 11'd4, 32'hCAFEF00D, 32'hF00FFFFF, 32'hCAFEF00D, 1'b0);

    plainWrite("lrsc_init", 4'd0, 11'd9, 32'h00000011);
    doLr("lrsc_ok", 4'd2, 11'd9, 32'h00000011);
    if (LrscEn) doSc("lrsc_ok", 4'd2, 11'd9, 32'h00000055, 32'd0, 1'b1);
    else doSc("lrsc_ok", 4'd2, 11'd9, 32'h00000055, 32'd1, 1'b0);
    checkOutput("lrsc_ok_mem", mem[9], LrscEn ? 32'h00000055 : 32'h00000011);

    doLr("lrsc_bad", 4'd2, 11'd9, LrscEn ? 32'h00000055 : 32'h00000011);
    plainWrite("lrsc_bad_kill", 4'd4, 11'd9, 32'h00000077);
    doSc("lrsc_bad", 4'd2, 11'd9, 32'h00000099, 32'd1, 1'b0);
    checkOutput("lrsc_bad_mem", mem[9], 32'h00000077);

    plainWrite("rst_amo_init", 4'd0, 11'd12, 32'h0000000A);
    doLr("rst_amo", 4'd3, 11'd12, 32'h0000000A);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 11'd12, 32'd5, {1'b1, F_ADD}, 4'd0);
    #1;
    checkOutput("rst_amo_gnt", DW'(in_gnt), 1);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_amo_out_req", DW'(out_req), 0);
    checkOutput("rst_amo_rvalid", DW'(in_rvalid), 0);
    checkOutput("rst_amo_gnt_low", DW'(in_gnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_amo_mem", mem[12], 32'h0000000A);
    checkOutput("rst_amo_rvalid_after", DW'(in_rvalid), 0);
    doSc("rst_amo", 4'd3, 11'd12, 32'h00000066, 32'd1, 1'b0);
    checkOutput("rst_amo_sc_mem", mem[12], 32'h0000000A);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
